// File: rtl/edge_stream_feeder_pkg.sv
// Shared constants and state encodings for the PE edge-input feeder.
package edge_stream_feeder_pkg;

  localparam int PE_WORD_W      = 768;
  localparam int DRAM_WORD_W    = 512;
  localparam int EDGE_W         = 96;
  localparam int EDGES_PER_WORD = PE_WORD_W / EDGE_W;
  localparam int WORD_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } fsm_state_e;

  // Bits currently held in the gearbox accumulator: 0, 256 or 512.
  typedef enum logic [1:0] {
    GB_EMPTY = 2'd0,
    GB_HALF  = 2'd1,
    GB_FULL  = 2'd2
  } gb_cnt_e;

endpackage

// File: rtl/edge_stream_feeder_gearbox.sv
// 512-to-768 bit repacker. Two DRAM beats feed one PE word plus half of the
// next; the output word is registered, so a word appears the cycle after the
// beat that completes it.
module gearbox_512to768
  import edge_stream_feeder_pkg::*;
#(
  parameter int DIN_W  = DRAM_WORD_W,
  parameter int DOUT_W = PE_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid_i,
  input  logic [DIN_W-1:0]  din_i,
  input  logic              flush_i,
  output logic [DOUT_W-1:0] dout_o,
  output logic              dout_valid_o
);

  localparam int HALF = DIN_W / 2;

  logic [DIN_W-1:0]  acc_q;
  gb_cnt_e           cnt_q;
  logic [DOUT_W-1:0] dout_q;
  logic              dvld_q;

  // Accumulate beats and emit a word whenever 768 bits are available; flush
  // drops any leftover half-beat so the next partition starts aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= GB_EMPTY;
      dout_q <= '0;
      dvld_q <= 1'b0;
    end else begin
      dvld_q <= 1'b0;
      if (flush_i) begin
        cnt_q <= GB_EMPTY;
      end else if (din_valid_i) begin
        unique case (cnt_q)
          GB_EMPTY: begin
            acc_q <= din_i;
            cnt_q <= GB_FULL;
          end
          GB_FULL: begin
            dout_q           <= {din_i[HALF-1:0], acc_q};
            acc_q[HALF-1:0]  <= din_i[DIN_W-1:HALF];
            cnt_q            <= GB_HALF;
            dvld_q           <= 1'b1;
          end
          GB_HALF: begin
            dout_q <= {din_i, acc_q[HALF-1:0]};
            cnt_q  <= GB_EMPTY;
            dvld_q <= 1'b1;
          end
          default: cnt_q <= GB_EMPTY;
        endcase
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dvld_q;

endmodule

// File: rtl/edge_stream_feeder.sv
// Transmit side of the PE edge-input interface: takes one partition command at
// a time, streams ceil(1.5*N) DRAM beats through the gearbox into N PE words,
// then holds until the PE reports the partition complete.
module edge_stream_feeder
  import edge_stream_feeder_pkg::*;
#(
  parameter int DRAM_W     = DRAM_WORD_W,
  parameter int FIFO_WIDTH = PE_WORD_W,
  parameter int CNT_W      = WORD_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_W-1:0]      cmd_words,
  input  logic                  cmd_active,
  input  logic [DRAM_W-1:0]     dram_rd_data,
  input  logic                  dram_rd_valid,
  output logic                  dram_rd_ready,
  output logic [FIFO_WIDTH-1:0] input_word,
  output logic                  input_valid,
  input  logic                  FIFO_full,
  output logic                  new_par_start,
  output logic                  new_par_active,
  output logic [CNT_W-1:0]      work_size,
  input  logic                  par_complete_sig,
  output logic                  par_done,
  output logic                  busy
);

  localparam logic [CNT_W+1:0] ONE_L = {{(CNT_W+1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_O = {{(CNT_W-1){1'b0}}, 1'b1};

  fsm_state_e       state_q;
  logic             cmd_ready_q, start_q, active_q, done_q;
  logic [CNT_W-1:0] work_q, out_left_q, out_left_d;
  logic [CNT_W+1:0] dram_left_q, dram_left_d, dram_need;
  logic [1:0]       since_q;   // cycles since START, saturating at 2
  logic             beat_acc, word_vld, go_drain;

  // Beats needed for N words: (3N+1)>>1 with headroom so large N cannot wrap.
  assign dram_need = ({1'b0, cmd_words, 1'b0} + {2'b00, cmd_words} + ONE_L) >> 1;

  assign dram_rd_ready = (state_q == ST_STREAM) && !FIFO_full && (dram_left_q != '0);
  assign beat_acc      = dram_rd_ready && dram_rd_valid;
  assign dram_left_d   = beat_acc ? dram_left_q - ONE_L : dram_left_q;
  assign out_left_d    = word_vld ? out_left_q - ONE_O : out_left_q;
  // The last word is already on the output register when dram_left hits 0.
  assign go_drain      = (state_q == ST_STREAM) && (dram_left_q == '0) && (out_left_d == '0);

  gearbox_512to768 #(
    .DIN_W  (DRAM_W),
    .DOUT_W (FIFO_WIDTH)
  ) u_gearbox (
    .clk          (clk),
    .rst          (rst),
    .din_valid_i  (beat_acc),
    .din_i        (dram_rd_data),
    .flush_i      (go_drain),
    .dout_o       (input_word),
    .dout_valid_o (word_vld)
  );

  // Partition FSM with registered handshake, strobe and descriptor outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      work_q      <= '0;
      out_left_q  <= '0;
      dram_left_q <= '0;
      since_q     <= 2'd0;
    end else begin
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      dram_left_q <= dram_left_d;
      out_left_q  <= out_left_d;
      if ((state_q == ST_STREAM || state_q == ST_DRAIN) && since_q != 2'd2)
        since_q <= since_q + 2'd1;
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            work_q      <= cmd_words;
            active_q    <= cmd_active;
            dram_left_q <= dram_need;
            out_left_q  <= cmd_words;
            start_q     <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          since_q <= 2'd1;
          state_q <= (active_q && work_q != '0) ? ST_STREAM : ST_DRAIN;
        end
        ST_STREAM: begin
          if (go_drain) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // PE counters only reflect the new partition two cycles after start.
          if (since_q == 2'd2 && par_complete_sig) begin
            done_q      <= 1'b1;
            active_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign input_valid    = word_vld;
  assign new_par_start  = start_q;
  assign new_par_active = active_q;
  assign work_size      = work_q;
  assign par_done       = done_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
